// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing one word memory between NUM_PORTS requesters
module mem_rr_arbiter #(
  parameter int NUM_PORTS       = 4,
  parameter int WORD_ADDR_WIDTH = 8
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic [NUM_PORTS-1:0]                       req_i,
  input  logic [NUM_PORTS-1:0][WORD_ADDR_WIDTH-3:0]  addr_i,
  input  logic [NUM_PORTS-1:0]                       wen_i,
  input  logic [NUM_PORTS-1:0][31:0]                 wdata_i,
  input  logic [NUM_PORTS-1:0][3:0]                  be_i,
  output logic [NUM_PORTS-1:0][31:0]                 rdata_o,
  output logic [NUM_PORTS-1:0]                       ready_o,
  output logic                                       mem_req_o,
  output logic [WORD_ADDR_WIDTH-3:0]                 mem_addr_o,
  output logic                                       mem_wen_o,
  output logic [31:0]                                mem_wdata_o,
  output logic [3:0]                                 mem_be_o,
  input  logic [31:0]                                mem_rdata_i,
  input  logic                                       mem_ready_i,
  output logic [$clog2(NUM_PORTS)-1:0]               gnt_idx_o,
  output logic                                       busy_o
);

  localparam int PW = $clog2(NUM_PORTS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   lock_q, lock_d;
  logic [PW-1:0]   ptr_q, ptr_d;

  logic            win_valid;
  logic [PW-1:0]   win_idx;
  logic            fwd_valid;
  logic [PW-1:0]   fwd_idx;
  int              scan_pos;
  logic [PW-1:0]   scan_idx;

  // Successor index with wrap at NUM_PORTS-1 (NUM_PORTS need not be a power of two).
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] idx);
    if (idx == PW'(NUM_PORTS - 1)) begin
      return '0;
    end
    return idx + PW'(1);
  endfunction

  // Round-robin winner: scan from ptr_q upward with wrap. Scanning offsets
  // from the far end lets the closest requester overwrite earlier hits.
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    scan_pos  = 0;
    scan_idx  = '0;
    for (int o = NUM_PORTS - 1; o >= 0; o--) begin
      scan_pos = int'(ptr_q) + o;
      if (scan_pos >= NUM_PORTS) begin
        scan_pos = scan_pos - NUM_PORTS;
      end
      scan_idx = PW'(scan_pos);
      if (req_i[scan_idx]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  // Forwarded port: fresh winner while idle, locked port while busy. A locked
  // port that drops its request forwards nothing (abort).
  always_comb begin
    if (state_q == BUSY) begin
      fwd_valid = req_i[lock_q];
      fwd_idx   = lock_q;
    end else begin
      fwd_valid = win_valid;
      fwd_idx   = win_idx;
    end
  end

  // Drive the shared memory port from the forwarded requester; zero otherwise.
  always_comb begin
    mem_req_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wen_o   = 1'b0;
    mem_wdata_o = '0;
    mem_be_o    = '0;
    if (fwd_valid) begin
      mem_req_o   = 1'b1;
      mem_addr_o  = addr_i[fwd_idx];
      mem_wen_o   = wen_i[fwd_idx];
      mem_wdata_o = wdata_i[fwd_idx];
      mem_be_o    = be_i[fwd_idx];
    end
  end

  // Route completion and read data only to the forwarded port; a memory
  // ready with no forwarded request is ignored.
  always_comb begin
    ready_o = '0;
    rdata_o = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (fwd_valid && mem_ready_i && (fwd_idx == PW'(k))) begin
        ready_o[k] = 1'b1;
        rdata_o[k] = mem_rdata_i;
      end
    end
  end

  // Status outputs; win_idx is already 0 when nobody requests.
  always_comb begin
    busy_o    = (state_q == BUSY);
    gnt_idx_o = (state_q == BUSY) ? lock_q : win_idx;
  end

  // Next-state logic: lock on a waited transaction, advance the pointer past
  // each completed grant, leave the pointer alone on abort.
  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          if (mem_ready_i) begin
            ptr_d = next_idx(win_idx);
          end else begin
            state_d = BUSY;
            lock_d  = win_idx;
          end
        end
      end
      BUSY: begin
        if (!req_i[lock_q]) begin
          state_d = IDLE;
        end else if (mem_ready_i) begin
          state_d = IDLE;
          ptr_d   = next_idx(lock_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      lock_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb/tb_mem_rr_arbiter.sv - directed scoreboard bench for mem_rr_arbiter with a wait-state mock memory
module tb_mem_rr_arbiter;

  localparam int NP = 4;
  localparam int AW = 8;
  localparam int WA = AW - 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NP-1:0]        req;
  logic [NP-1:0][WA-1:0] addr;
  logic [NP-1:0]        wen;
  logic [NP-1:0][31:0]  wdata;
  logic [NP-1:0][3:0]   be;
  logic [NP-1:0][31:0]  rdata;
  logic [NP-1:0]        ready;
  logic                 mem_req;
  logic [WA-1:0]        mem_addr;
  logic                 mem_wen;
  logic [31:0]          mem_wdata;
  logic [3:0]           mem_be;
  logic [31:0]          mem_rdata;
  logic                 mem_ready;
  logic [1:0]           gnt_idx;
  logic                 busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int          port;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  mem_rr_arbiter #(.NUM_PORTS(NP), .WORD_ADDR_WIDTH(AW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .addr_i      (addr),
    .wen_i       (wen),
    .wdata_i     (wdata),
    .be_i        (be),
    .rdata_o     (rdata),
    .ready_o     (ready),
    .mem_req_o   (mem_req),
    .mem_addr_o  (mem_addr),
    .mem_wen_o   (mem_wen),
    .mem_wdata_o (mem_wdata),
    .mem_be_o    (mem_be),
    .mem_rdata_i (mem_rdata),
    .mem_ready_i (mem_ready),
    .gnt_idx_o   (gnt_idx),
    .busy_o      (busy)
  );

  // Mock memory: completes after `delay` wait states, counter restarts whenever
  // the request drops or a transaction completes.
  logic [31:0] mem [64];
  int          delay = 0;
  int          cnt;

  assign mem_ready = mem_req && (cnt == delay);
  assign mem_rdata = (mem_ready && !mem_wen) ? mem[mem_addr] : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0;
      for (int i = 0; i < 64; i++) mem[i] <= (i == 0) ? 32'hDEADBEEF : 32'hF1F1F1F1;
    end else if (!mem_req || mem_ready) begin
      cnt <= 0;
      if (mem_ready && mem_wen) begin
        for (int b = 0; b < 4; b++) begin
          if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end else begin
      cnt <= cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every completion must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready_onehot0", 64'($onehot0(ready)), 64'd1);
      for (int k = 0; k < NP; k++) begin
        if (ready[k]) begin
          if (sb.size() == 0) begin
            chk("unexpected_ready_port", 64'(k), 64'd99);
          end else begin
            mon_e = sb.pop_front();
            chk("sb_port", 64'(k), 64'(mon_e.port));
            chk("sb_rdata", 64'(rdata[k]), 64'(mon_e.data));
          end
        end else if (rdata[k] !== 32'h0) begin
          chk("rdata_nongranted", 64'(rdata[k]), 64'd0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = '0;
    addr  = '0;
    wen   = '0;
    wdata = '0;
    be    = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic push(input int p, input logic [31:0] d);
    exp_t e;
    e.port = p;
    e.data = d;
    sb.push_back(e);
  endtask

  // Waits for ready on port p over up to `budget` negedges; returns at posedge+1 after it.
  task automatic wait_ready(input int p, input int budget, output int c);
    c = 0;
    forever begin
      @(negedge clk);
      if (ready[p] || c >= budget) break;
      c++;
    end
    chk($sformatf("wait_ready_p%0d", p), 64'(ready[p]), 64'd1);
    cyc();
  endtask

  initial begin
    int c;
    // Reset then idle.
    do_reset();
    @(negedge clk);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(ready), 64'd0);
    chk("rst_gnt", 64'(gnt_idx), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
    chk("rst_rdata", 64'(|rdata), 64'd0);

    // Single read, delay 2, port 2, word 0.
    cyc();
    delay   = 2;
    req[2]  = 1'b1;
    addr[2] = '0;
    be[2]   = 4'hF;
    push(2, 32'hDEADBEEF);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rd_mem_req_c%0d", i), 64'(mem_req), 64'd1);
      chk($sformatf("rd_busy_c%0d", i), 64'(busy), 64'(i > 0));
      chk($sformatf("rd_ready_c%0d", i), 64'(ready), (i == 2) ? 64'h4 : 64'h0);
      chk($sformatf("rd_gnt_c%0d", i), 64'(gnt_idx), 64'd2);
      cyc();
    end
    req[2] = 1'b0;
    @(negedge clk);
    chk("rd_done_mem_req", 64'(mem_req), 64'd0);
    chk("rd_done_busy", 64'(busy), 64'd0);
    // Pointer is now 3: ports 1 and 3 contend, 3 wins, then the pointer wraps to 0 and 1 wins.
    cyc();
    delay   = 0;
    req[1]  = 1'b1;
    addr[1] = WA'(1);
    req[3]  = 1'b1;
    addr[3] = WA'(3);
    push(3, 32'hF1F1F1F1);
    push(1, 32'hF1F1F1F1);
    @(negedge clk);
    chk("ptr3_gnt", 64'(gnt_idx), 64'd3);
    cyc();
    req[3] = 1'b0;
    @(negedge clk);
    chk("ptr_wrap_gnt", 64'(gnt_idx), 64'd1);
    cyc();
    req[1] = 1'b0;

    // All ports requesting, zero wait: grants rotate 0,1,2,3,0.
    do_reset();
    delay = 0;
    for (int k = 0; k < NP; k++) begin
      req[k]  = 1'b1;
      addr[k] = WA'(k);
    end
    push(0, 32'hDEADBEEF);
    push(1, 32'hF1F1F1F1);
    push(2, 32'hF1F1F1F1);
    push(3, 32'hF1F1F1F1);
    push(0, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("rr_gnt_%0d", i), 64'(gnt_idx), 64'(i % NP));
      chk($sformatf("rr_ready_%0d", i), 64'(ready), 64'(1 << (i % NP)));
      cyc();
    end
    req = '0;

    // Lock hold: port 1 with delay 3, port 0 arrives mid-transaction.
    do_reset();
    delay   = 3;
    req[1]  = 1'b1;
    addr[1] = WA'(1);
    push(1, 32'hF1F1F1F1);
    push(0, 32'hDEADBEEF);
    @(negedge clk);
    chk("lock_gnt_c0", 64'(gnt_idx), 64'd1);
    cyc();
    req[0]  = 1'b1;
    addr[0] = '0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      chk($sformatf("lock_gnt_c%0d", i), 64'(gnt_idx), 64'd1);
      chk($sformatf("lock_ready1_c%0d", i), 64'(ready[1]), 64'(i == 3));
      chk($sformatf("lock_ready0_c%0d", i), 64'(ready[0]), 64'd0);
      if (i < 3) cyc();
    end
    cyc();
    req[1] = 1'b0;
    @(negedge clk);
    chk("lock_next_gnt", 64'(gnt_idx), 64'd0);
    chk("lock_next_mem_addr", 64'(mem_addr), 64'd0);
    wait_ready(0, 10, c);
    req[0] = 1'b0;

    // Byte-enable write from port 3, read back via port 0.
    do_reset();
    delay    = 1;
    req[3]   = 1'b1;
    wen[3]   = 1'b1;
    addr[3]  = WA'(1);
    wdata[3] = 32'hAABBCCDD;
    be[3]    = 4'b0101;
    push(3, 32'h0);
    @(negedge clk);
    chk("wr_mem_wen", 64'(mem_wen), 64'd1);
    chk("wr_mem_be", 64'(mem_be), 64'h5);
    chk("wr_mem_wdata", 64'(mem_wdata), 64'hAABBCCDD);
    chk("wr_mem_addr", 64'(mem_addr), 64'd1);
    wait_ready(3, 10, c);
    req[3]  = 1'b0;
    wen[3]  = 1'b0;
    req[0]  = 1'b1;
    addr[0] = WA'(1);
    be[0]   = 4'hF;
    push(0, 32'hF1BBF1DD);
    wait_ready(0, 10, c);
    req[0] = 1'b0;

    // Abort: port 1 drops its request after 2 cycles of a delay-5 read.
    do_reset();
    delay   = 5;
    req[1]  = 1'b1;
    addr[1] = WA'(1);
    @(negedge clk);
    chk("ab_gnt_c0", 64'(gnt_idx), 64'd1);
    cyc();
    @(negedge clk);
    chk("ab_busy_c1", 64'(busy), 64'd1);
    cyc();
    req[1] = 1'b0;
    @(negedge clk);
    chk("ab_mem_req", 64'(mem_req), 64'd0);
    chk("ab_ready", 64'(ready), 64'd0);
    cyc();
    // Pointer must still be 0, so port 1 beats port 2; the memory restarts its full wait.
    req[1]  = 1'b1;
    req[2]  = 1'b1;
    addr[2] = WA'(2);
    push(1, 32'hF1F1F1F1);
    @(negedge clk);
    chk("ab_idle_busy", 64'(busy), 64'd0);
    chk("ab_ptr_kept_gnt", 64'(gnt_idx), 64'd1);
    wait_ready(1, 10, c);
    // First of the six cycles was the negedge above; five more to reach ready.
    chk("ab_restart_wait", 64'(c), 64'd4);
    req[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_gnt_c0", 64'(gnt_idx), 64'd2);
    cyc();
    @(negedge clk);
    chk("rst_mid_busy_c1", 64'(busy), 64'd1);
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 64'(busy), 64'd0);
    chk("rst_mid_ready", 64'(ready), 64'd0);
    req = '0;
    cyc();
    rst_n = 1'b1;
    cyc();
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_rr_arbiter.md
# mem_rr_arbiter

Round-robin arbiter that shares one single-port word memory between `NUM_PORTS` requesters using the req/ready memory protocol of the crossbar testbench. Each requester sees a private memory port. The arbiter forwards one transaction at a time to the shared memory port and locks the grant until the memory asserts ready. It sits between the crossbar master ports and a memory such as the testbench's mock memory, and it tolerates arbitrary memory wait states.

## Interface
Parameters:
- `NUM_PORTS`, default 4: number of requester ports. Must be ≥ 2.
- `WORD_ADDR_WIDTH`, default 8: byte-address width. Word addresses are `WORD_ADDR_WIDTH-2` bits wide.

Ports:
- `clk_i`  in  1  system clock; all state updates on its rising edge.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `req_i`  in  [NUM_PORTS]  per-requester request.
- `addr_i`  in  [NUM_PORTS][WORD_ADDR_WIDTH-3:0]  per-requester word address.
- `wen_i`  in  [NUM_PORTS]  per-requester write enable (1 = write).
- `wdata_i`  in  [NUM_PORTS][31:0]  per-requester write data.
- `be_i`  in  [NUM_PORTS][3:0]  per-requester byte enables.
- `rdata_o`  out  [NUM_PORTS][31:0]  read data; valid only with the matching `ready_o`.
- `ready_o`  out  [NUM_PORTS]  transaction-complete strobe to each requester.
- `mem_req_o`  out  1  request to the shared memory.
- `mem_addr_o`  out  [WORD_ADDR_WIDTH-3:0]  forwarded address.
- `mem_wen_o`  out  1  forwarded write enable.
- `mem_wdata_o`  out  [31:0]  forwarded write data.
- `mem_be_o`  out  [3:0]  forwarded byte enables.
- `mem_rdata_i`  in  [31:0]  memory read data; valid when `mem_ready_i` = 1.
- `mem_ready_i`  in  1  memory completion strobe.
- `gnt_idx_o`  out  [$clog2(NUM_PORTS)-1:0]  index of the currently forwarded port; 0 when idle.
- `busy_o`  out  1  high while the grant is locked (state BUSY).

## Operation
- Requester protocol: a requester raises `req_i` with stable addr/wen/wdata/be and holds them until the cycle its `ready_o` is high. It may issue back-to-back requests starting the cycle after `ready_o`.
- State: `state_q` in {IDLE, BUSY}, `lock_q` (locked port index), `ptr_q` (round-robin priority pointer). All are `$clog2(NUM_PORTS)` bits where applicable.
- Winner selection in IDLE: the first index `i` with `req_i[i]` = 1, scanning `ptr_q`, `ptr_q+1`, …, `NUM_PORTS-1`, 0, …, `ptr_q-1` (modulo `NUM_PORTS`).
- Forwarded port: the winner in IDLE, `lock_q` in BUSY. Its req/addr/wen/wdata/be are driven combinationally onto the `mem_*` outputs.
- With no forwarded port (IDLE, no requests), all `mem_*` outputs are 0.
- `ready_o[k]` = `mem_ready_i` AND (k == forwarded port). `rdata_o[k]` = `mem_rdata_i` under the same condition, else 0. Non-granted ports always see 0.
- Transitions:
  - IDLE, winner w, `mem_ready_i` = 1 (zero-wait memory): stay IDLE; `ptr_q` ← (w+1) mod `NUM_PORTS`.
  - IDLE, winner w, `mem_ready_i` = 0: go to BUSY; `lock_q` ← w.
  - BUSY, `req_i[lock_q]` = 1, `mem_ready_i` = 1: go to IDLE; `ptr_q` ← (`lock_q`+1) mod `NUM_PORTS`.
  - BUSY, `req_i[lock_q]` = 1, `mem_ready_i` = 0: stay BUSY.
  - BUSY, `req_i[lock_q]` = 0 (protocol violation / abort): go to IDLE; `ptr_q` unchanged; `mem_req_o` = 0 that cycle; no `ready_o`.
- Requests on other ports never preempt a locked grant.
- `mem_ready_i` while `mem_req_o` = 0 is ignored.

## Timing
- Reset (async, `rst_ni` = 0): `state_q` = IDLE, `ptr_q` = 0, `lock_q` = 0. `busy_o` = 0, `gnt_idx_o` = 0. All `ready_o`, `rdata_o` and `mem_*` outputs are 0 when no requests are present.
- Arbitration latency is 0 cycles: a request arriving at an idle arbiter appears on `mem_req_o` in the same cycle.
- Transaction latency equals the memory's wait states; the arbiter adds none.
- A port granted with zero wait states completes in 1 cycle. A new winner can be forwarded in the very next cycle.
- Fairness: with all ports requesting continuously, grants rotate 0, 1, …, `NUM_PORTS-1`, 0, … Each port waits at most `NUM_PORTS-1` transactions.
- `ptr_q` wraps from `NUM_PORTS-1` to 0.
- Reset mid-transaction: the arbiter returns to IDLE immediately and the pending transaction is dropped without `ready_o`.

## Test plan
- Reset then idle: all `req_i` = 0 -> `mem_req_o` = 0, `busy_o` = 0, all `ready_o` = 0, `gnt_idx_o` = 0.
- Single read, memory delay 2, port 2 reads word 0 -> `mem_req_o` high for 3 cycles; `ready_o[2]` high in cycle 3 with `rdata_o[2]` = 0xDEADBEEF; `busy_o` high in cycles 1–2; `ptr_q` becomes 3.
- All 4 ports request continuously, delay 0 -> grant order 0, 1, 2, 3, 0 on consecutive cycles; exactly one `ready_o` bit high per cycle.
- Lock hold, delay 3, port 1 granted, port 0 raises its request mid-transaction -> `gnt_idx_o` stays 1 until `ready_o[1]`; port 0 is served next (scan starts at 2, finds none, wraps to 0).
- Byte-enable write, port 3 writes 0xAABBCCDD with `be` = 4'b0101 to word 1, then port 0 reads word 1 -> returns 0xF1BBF1DD.
- Abort, delay 5, port 1 drops `req_i` after 2 cycles -> no `ready_o`, arbiter returns to IDLE, `ptr_q` unchanged, memory delay counter resets; `rst_ni` asserted mid-transaction gives the same result.
